mc_controller: RTL and testbench
================================

# mc_controller

Multicycle MIPS control unit: a Moore state machine plus ALU decoder that sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath enable and mux select inside `cpu`. Sits directly upstream of the datapath registers (PC, IR, register file, memory port) that produce the `pc`, `dataaddr`, `writedata` and `memwrite` signals seen at the `cpu` boundary.

## Interface
Parameters: none.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces FETCH
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BEQEX
- pcen  out  1  PC load enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- regwrite  out  1  register-file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- regdst  out  1  destination select: 0 = rt, 1 = rd
- alusrca  out  1  ALU A select: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop add, pcsrc=00, pcwrite=1. Next state: DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop add (branch target into ALUOut).
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) -> RTYPEEX
  - beq (000100) -> BEQEX
  - addi (001000) -> ADDIEX
  - j (000010) -> JEX
  - any other opcode -> FETCH, with illegal=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop funct -> RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- pcen = pcwrite | (branch & zero) [| (bne & ~zero) when configured].
- ALU decode: aluop add -> 010; sub -> 110; funct -> 100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111. Unknown funct yields 010.
- Unlisted outputs are 0 in every state.

## Timing
- Outputs are pure combinational decode of the state register (plus `zero`/`op`/`funct`). There is no output register.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset asserted: state = FETCH immediately, without waiting for a clock edge. While reset is high, pcen, irwrite, regwrite and memwrite are forced 0. The other outputs show their FETCH values.
- Reset deasserted mid-instruction: the partial instruction is abandoned, with no writeback or memwrite issued. The first rising edge after release executes FETCH.
- `zero` is sampled only combinationally in BEQEX (and BNEEX). It is ignored in all other states.

## Configuration
- `MC_BNE_EN` defined: adds state BNEEX. DECODE with op 000101 goes to BNEEX. BNEEX has the BEQEX datapath settings with bne=1 and branch=0, then goes to FETCH (3 cycles).
- `MC_BNE_EN` undefined: op 000101 is illegal (pulse, return to FETCH). The bne term is absent from pcen.

## Structure
- Shared package `mc_pkg`:
  - state enum
  - opcode and funct localparams
  - aluop and alucontrol encodings
  - alusrcb and pcsrc encodings
  - u1/u32 types come from common.svh
- One sub-module, `mc_aludec`: combinational, (aluop, funct) -> alucontrol. The FSM itself lives in mc_controller.

## Test plan
- Reset pulse of 1 ns, mid-cycle -> state FETCH without a clock edge. memwrite, regwrite and pcen are 0 while reset is high. irwrite=1 and pcen=1 in the first post-reset cycle.
- op=001000 (addi) -> FETCH, DECODE, ADDIEX, ADDIWB. regwrite=1 and regdst=0 only in cycle 4, then FETCH.
- op=000000, funct=100000, then funct=101010 -> RTYPEEX alucontrol 010, then 111. RTYPEWB regdst=1, regwrite=1. Four cycles each.
- op=100011 (lw) then op=101011 (sw) -> lw takes 5 cycles with iord=1 in MEMRD and memtoreg=1 in MEMWB. sw takes 4 cycles with memwrite=1 exactly one cycle.
- op=000100 with zero=1, then with zero=0 -> BEQEX pcen=1 (pcsrc=01), then pcen=0. Both take 3 cycles.
- op=000101 -> with `MC_BNE_EN`, zero=0 gives pcen=1 in BNEEX. Without it, illegal pulses in DECODE and the next state is FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
//==============================================================================
// mc_pkg : shared types and encodings for the multicycle MIPS controller
// Rev 1.0
//==============================================================================
`default_nettype none

package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11,
      BNEEX   = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_aludec.sv
//==============================================================================
// mc_aludec : combinational ALU decoder, (aluop, funct) -> alucontrol
// Rev 1.0
//==============================================================================
`default_nettype none

module mc_aludec
   import mc_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
//==============================================================================
// mc_controller : multicycle MIPS Moore control FSM driving the datapath
// Optional feature macro MC_BNE_EN adds the BNEEX state. Rev 1.0
//==============================================================================
`default_nettype none

module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal
);

   state_t state, next_state;
   aluop_t aluop;
   logic   pcwrite, branch;
   logic   memwrite_raw, irwrite_raw, regwrite_raw;
`ifdef MC_BNE_EN
   logic   bne;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state   = FETCH;
      pcwrite      = 1'b0;
      branch       = 1'b0;
`ifdef MC_BNE_EN
      bne          = 1'b0;
`endif
      memwrite_raw = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      iord         = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = SRCB_REG;
      pcsrc        = PC_ALU;
      aluop        = ALUOP_ADD;
      illegal      = 1'b0;
      case (state)
         FETCH: begin
            irwrite_raw = 1'b1;
            alusrcb     = SRCB_FOUR;
            pcwrite     = 1'b1;
            next_state  = DECODE;
         end
         DECODE: begin
            // Speculatively compute the branch target into ALUOut
            alusrcb = SRCB_IMMSH;
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = RTYPEEX;
               OP_BEQ:       next_state = BEQEX;
               OP_ADDI:      next_state = ADDIEX;
               OP_J:         next_state = JEX;
`ifdef MC_BNE_EN
               OP_BNE:       next_state = BNEEX;
`endif
               default: begin
                  next_state = FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            next_state = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            iord       = 1'b1;
            next_state = MEMWB;
         end
         MEMWB: begin
            memtoreg     = 1'b1;
            regwrite_raw = 1'b1;
         end
         MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
         end
         RTYPEEX: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_FUNCT;
            next_state = RTYPEWB;
         end
         RTYPEWB: begin
            regdst       = 1'b1;
            regwrite_raw = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PC_ALUOUT;
            branch  = 1'b1;
         end
`ifdef MC_BNE_EN
         BNEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PC_ALUOUT;
            bne     = 1'b1;
         end
`endif
         ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            next_state = ADDIWB;
         end
         ADDIWB: begin
            regwrite_raw = 1'b1;
         end
         JEX: begin
            pcsrc   = PC_JUMP;
            pcwrite = 1'b1;
         end
         default: next_state = FETCH;
      endcase
   end

   // Architectural write strobes are held off for the whole reset pulse
`ifdef MC_BNE_EN
   assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne & ~zero));
`else
   assign pcen     = ~reset & (pcwrite | (branch & zero));
`endif
   assign memwrite = ~reset & memwrite_raw;
   assign irwrite  = ~reset & irwrite_raw;
   assign regwrite = ~reset & regwrite_raw;

   mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
//==============================================================================
// tb_mc_controller : directed self-checking bench for mc_controller
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [15:0] outs;

   int checks = 0;
   int errors = 0;

   // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,illegal}
   localparam logic [15:0] E_FETCH   = 16'hA044;
   localparam logic [15:0] E_DECODE  = 16'h00C4;
   localparam logic [15:0] E_DEC_ILL = 16'h00C5;
   localparam logic [15:0] E_MEMADR  = 16'h0184;
   localparam logic [15:0] E_MEMRD   = 16'h0804;
   localparam logic [15:0] E_MEMWB   = 16'h1404;
   localparam logic [15:0] E_MEMWR   = 16'h4804;
   localparam logic [15:0] E_RTYPEWB = 16'h1204;
   localparam logic [15:0] E_ADDIEX  = 16'h0184;
   localparam logic [15:0] E_ADDIWB  = 16'h1004;
   localparam logic [15:0] E_JEX     = 16'h8024;
   localparam logic [15:0] E_BRANCH  = 16'h011C;
   localparam logic [15:0] E_RSTHELD = 16'h0044;
   localparam logic [15:0] M_ALL     = 16'hFFFF;
   localparam logic [15:0] M_NOALU   = 16'hFFF1;

   assign outs = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                  alusrcb, pcsrc, alucontrol, illegal};

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1;
      op    = 6'b000000;
      funct = 6'b000000;
      zero  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs !== E_RSTHELD) begin
         errors++;
         $display("FAIL reset_held got %h want %h", outs, E_RSTHELD);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (outs !== E_FETCH) begin
         errors++;
         $display("FAIL reset_release got %h want %h", outs, E_FETCH);
      end
   endtask

   task automatic test_addi();
      logic [15:0] e [0:3];
      logic [15:0] m [0:3];
      e = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB};
      m = '{M_ALL, M_ALL, M_ALL, M_NOALU};
      op = 6'b001000;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ((outs & m[i]) !== (e[i] & m[i])) begin
            errors++;
            $display("FAIL addi cyc%0d got %h want %h", i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_rtype(input logic [5:0] fn, input logic [2:0] ctrl);
      logic [15:0] e [0:3];
      logic [15:0] m [0:3];
      e = '{E_FETCH, E_DECODE, 16'h0100 | {12'd0, ctrl, 1'b0}, E_RTYPEWB};
      m = '{M_ALL, M_ALL, M_ALL, M_NOALU};
      op    = 6'b000000;
      funct = fn;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ((outs & m[i]) !== (e[i] & m[i])) begin
            errors++;
            $display("FAIL rtype_%b cyc%0d got %h want %h", fn, i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_lw();
      logic [15:0] e [0:4];
      logic [15:0] m [0:4];
      e = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
      m = '{M_ALL, M_ALL, M_ALL, M_NOALU, M_NOALU};
      op = 6'b100011;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ((outs & m[i]) !== (e[i] & m[i])) begin
            errors++;
            $display("FAIL lw cyc%0d got %h want %h", i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   // advance=0 leaves the FSM parked in MEMWR for the mid-instruction reset test
   task automatic test_sw(input bit advance);
      logic [15:0] e [0:3];
      logic [15:0] m [0:3];
      e = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
      m = '{M_ALL, M_ALL, M_ALL, M_NOALU};
      op = 6'b101011;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ((outs & m[i]) !== (e[i] & m[i])) begin
            errors++;
            $display("FAIL sw cyc%0d got %h want %h", i, outs, e[i]);
         end
         if (advance || i < 3) begin
            @(posedge clk); @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_midop();
      test_sw(1'b0);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (outs !== E_RSTHELD) begin
         errors++;
         $display("FAIL midop_reset_held got %h want %h", outs, E_RSTHELD);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (outs !== E_FETCH) begin
         errors++;
         $display("FAIL midop_reset_release got %h want %h", outs, E_FETCH);
      end
   endtask

   task automatic test_beq(input logic z);
      logic [15:0] e [0:2];
      e = '{E_FETCH, E_DECODE, E_BRANCH | {z, 15'd0}};
      op   = 6'b000100;
      zero = z;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL beq_z%0b cyc%0d got %h want %h", z, i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      zero = 1'b0;
   endtask

   task automatic test_j();
      logic [15:0] e [0:2];
      logic [15:0] m [0:2];
      e = '{E_FETCH, E_DECODE, E_JEX};
      m = '{M_ALL, M_ALL, M_NOALU};
      op = 6'b000010;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ((outs & m[i]) !== (e[i] & m[i])) begin
            errors++;
            $display("FAIL j cyc%0d got %h want %h", i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_bne(input logic z);
`ifdef MC_BNE_EN
      logic [15:0] e [0:2];
      e = '{E_FETCH, E_DECODE, E_BRANCH | {~z, 15'd0}};
      op   = 6'b000101;
      zero = z;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL bne_z%0b cyc%0d got %h want %h", z, i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
`else
      logic [15:0] e [0:1];
      e = '{E_FETCH, E_DEC_ILL};
      op   = 6'b000101;
      zero = z;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL bne_illegal_z%0b cyc%0d got %h want %h", z, i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
`endif
      zero = 1'b0;
   endtask

   task automatic test_illegal();
      logic [15:0] e [0:1];
      e = '{E_FETCH, E_DEC_ILL};
      op = 6'b111111;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL illegal cyc%0d got %h want %h", i, outs, e[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (outs !== E_FETCH) begin
         errors++;
         $display("FAIL illegal_return got %h want %h", outs, E_FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_rtype(6'b100000, 3'b010);
      test_rtype(6'b101010, 3'b111);
      test_rtype(6'b100010, 3'b110);
      test_rtype(6'b100100, 3'b000);
      test_rtype(6'b100101, 3'b001);
      test_rtype(6'b111111, 3'b010);
      test_lw();
      test_sw(1'b1);
      test_beq(1'b1);
      test_beq(1'b0);
      test_j();
      test_bne(1'b0);
      test_bne(1'b1);
      test_illegal();
      test_reset_midop();
      test_addi();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
